generic_demux1x4_stream: RTL and testbench

- Inverse of the team's 4:1 selector. Routes one N-bit input stream to one of four N-bit output channels.
- Input side and each output channel use valid/ready handshakes.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Used wherever a single producer (datapath result, UART byte, keypad code) must be steered to one of four consumers.

---
 rtl/generic_demux_pkg.sv | 21 ++
 rtl/generic_demux1x4_stream_slot.sv | 50 +++++
 rtl/generic_demux1x4_stream.sv | 88 ++++++++
 tb/tb_generic_demux1x4_stream.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/generic_demux_pkg.sv
// generic_demux_pkg
// Shared constants, the channel index type and small helpers for the
// 1-to-4 stream demultiplexer.
package generic_demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // Next channel in rotation; the 2-bit width gives the 3 -> 0 wrap.
  function automatic ch_idx_t next_ch(input ch_idx_t cur);
    next_ch = cur + 2'd1;
  endfunction

  // One-hot decode of a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t idx);
    ch_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/generic_demux1x4_stream_slot.sv
// demux_slot
// One-entry holding register for a single output channel. A word loaded
// here stays visible until its consumer takes it. A drain and a load on
// the same edge replace the word and keep valid set, so a consumer that
// is always ready sees one word per cycle.
module demux_slot #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [n-1:0] din,
  input  logic         ready,
  output logic [n-1:0] dout,
  output logic         valid,
  output logic         can_load
);

  logic [n-1:0] data_r;
  logic         valid_r;

  // Data register: loads on accept, otherwise keeps the last word (even after draining).
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= {n{1'b0}};
    end else if (load) begin
      data_r <= din;
    end else begin
      data_r <= data_r;
    end
  end

  // Valid flag: load wins over drain, drain clears, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign dout     = data_r;
  assign valid    = valid_r;
  assign can_load = !valid_r || ready;

endmodule

// File: rtl/generic_demux1x4_stream.sv
// generic_demux1x4_stream
// Steers one valid/ready input stream to one of four output channels,
// each buffered by its own one-entry slot so a stalled consumer blocks
// only its own channel.
// Optional build macro: DEMUX_ROUND_ROBIN_EN -- a registered pointer
// replaces sel as the destination and advances on every accepted word.
module generic_demux1x4_stream
  import generic_demux_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] x,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [1:0]   sel,
  output logic [n-1:0] f0,
  output logic [n-1:0] f1,
  output logic [n-1:0] f2,
  output logic [n-1:0] f3,
  output logic [3:0]   f_valid,
  input  logic [3:0]   f_ready
);

  ch_idx_t           dest_s;
  logic              accept_s;
  logic [NUM_CH-1:0] load_s;
  logic [NUM_CH-1:0] can_load_s;
  logic [NUM_CH-1:0] valid_s;
  logic [n-1:0]      dout_s [NUM_CH];

`ifdef DEMUX_ROUND_ROBIN_EN
  ch_idx_t ptr_r;
  logic    sel_unused_s;

  // sel has no role when the pointer chooses the destination.
  assign sel_unused_s = ^sel;

  // Rotation pointer: moves only on an accepted word, so a blocked channel is waited on, never skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= 2'd0;
    end else if (accept_s) begin
      ptr_r <= next_ch(ptr_r);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign dest_s = ptr_r;
`else
  assign dest_s = sel;
`endif

  // Input handshake: ready follows the destination slot; an accept loads only that slot.
  always_comb begin
    x_ready  = can_load_s[dest_s];
    accept_s = x_valid && x_ready && !reset;
    if (accept_s) begin
      load_s = ch_onehot(dest_s);
    end else begin
      load_s = {NUM_CH{1'b0}};
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(
      .n(n)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s[i]),
      .din      (x),
      .ready    (f_ready[i]),
      .dout     (dout_s[i]),
      .valid    (valid_s[i]),
      .can_load (can_load_s[i])
    );
  end

  assign f0      = dout_s[0];
  assign f1      = dout_s[1];
  assign f2      = dout_s[2];
  assign f3      = dout_s[3];
  assign f_valid = valid_s;

endmodule

// File: tb/tb_generic_demux1x4_stream.sv
// tb_generic_demux1x4_stream
// Scoreboard bench: a behavioural model of the four slots predicts
// x_ready, f_valid and channel data; accepted words are queued per
// channel and popped when the consumer drains them.
module tb_generic_demux1x4_stream;

  logic       clk;
  logic       reset;
  logic [7:0] x;
  logic       x_valid;
  logic       x_ready;
  logic [1:0] sel;
  logic [7:0] f0, f1, f2, f3;
  logic [3:0] f_valid;
  logic [3:0] f_ready;

  logic [7:0] fo [4];
  assign fo[0] = f0;
  assign fo[1] = f1;
  assign fo[2] = f2;
  assign fo[3] = f3;

  // model state
  logic [3:0] mvalid;
  logic [7:0] mdata [4];
  logic [1:0] mptr;
  logic [7:0] exp_q [4][$];

  int total;
  int bad;

  generic_demux1x4_stream #(.n(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .sel     (sel),
    .f0      (f0),
    .f1      (f1),
    .f2      (f2),
    .f3      (f3),
    .f_valid (f_valid),
    .f_ready (f_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mvalid = 4'b0000;
    mptr   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      mdata[i] = 8'h00;
      exp_q[i].delete();
    end
  endtask

  // One clock cycle: drive, check x_ready and drained words, clock, check slot state.
  task automatic step(input logic rs, input logic xv, input logic [7:0] xd,
                      input logic [1:0] s, input logic [3:0] fr);
    logic [1:0] d;
    logic       er;
    logic       acc;
    logic [7:0] w;
    reset   = rs;
    x_valid = xv;
    x       = xd;
    sel     = s;
    f_ready = fr;
    @(negedge clk);
`ifdef DEMUX_ROUND_ROBIN_EN
    d = mptr;
`else
    d = s;
`endif
    er  = !mvalid[d] || fr[d];
    acc = xv && er && !rs;
    chk("x_ready", {31'd0, x_ready}, {31'd0, er});
    if (!rs) begin
      for (int i = 0; i < 4; i++) begin
        if (mvalid[i] && fr[i] && exp_q[i].size() > 0) begin
          w = exp_q[i].pop_front();
          chk($sformatf("drain_f%0d", i), {24'd0, fo[i]}, {24'd0, w});
        end
      end
    end
    @(posedge clk);
    #1;
    if (rs) begin
      model_clear();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc && d == i[1:0]) begin
          mvalid[i] = 1'b1;
          mdata[i]  = xd;
          exp_q[i].push_back(xd);
        end else if (fr[i]) begin
          mvalid[i] = 1'b0;
        end
      end
      if (acc) mptr = mptr + 2'd1;
    end
    chk("f_valid", {28'd0, f_valid}, {28'd0, mvalid});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f%0d", i), {24'd0, fo[i]}, {24'd0, mdata[i]});
    end
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b1;
    x_valid = 1'b1;
    x       = 8'hAA;
    sel     = 2'd0;
    f_ready = 4'b0000;
    total   = 0;
    bad     = 0;
    model_clear();
    @(posedge clk);
    #1;

    // reset held two edges with a pending word: nothing is accepted
    step(1'b1, 1'b1, 8'hAA, 2'd0, 4'b0000);
    step(1'b1, 1'b1, 8'hAA, 2'd0, 4'b0000);
    step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000);

`ifdef DEMUX_ROUND_ROBIN_EN
    // rotation AA..EE to f0,f1,f2,f3,f0 with all consumers ready
    step(1'b0, 1'b1, 8'hAA, 2'd0, 4'b1111);
    step(1'b0, 1'b1, 8'hBB, 2'd0, 4'b1111);
    step(1'b0, 1'b1, 8'hCC, 2'd0, 4'b1111);
    step(1'b0, 1'b1, 8'hDD, 2'd0, 4'b1111);
    step(1'b0, 1'b1, 8'hEE, 2'd0, 4'b1111);
    // stall f1: F1 lands there, then fill the rest until the pointer blocks on f1
    step(1'b0, 1'b1, 8'hF1, 2'd0, 4'b1101);
    step(1'b0, 1'b1, 8'hF2, 2'd0, 4'b0000);
    step(1'b0, 1'b1, 8'hF3, 2'd0, 4'b0000);
    step(1'b0, 1'b1, 8'hF4, 2'd0, 4'b0000);
    step(1'b0, 1'b1, 8'hF5, 2'd0, 4'b1101);
    step(1'b0, 1'b1, 8'hF5, 2'd0, 4'b1101);
    step(1'b0, 1'b1, 8'hF5, 2'd0, 4'b1111);
    step(1'b0, 1'b0, 8'h00, 2'd0, 4'b1111);
`else
    // single route to f2, then x_ready low only while f2 is the destination
    step(1'b0, 1'b1, 8'h5C, 2'd2, 4'b0000);
    step(1'b0, 1'b0, 8'h00, 2'd2, 4'b0000);
    step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000);
    step(1'b0, 1'b1, 8'h99, 2'd2, 4'b0000);
    step(1'b0, 1'b0, 8'h00, 2'd0, 4'b1111);
    // back-pressure isolation between f1 and f3
    step(1'b0, 1'b1, 8'h11, 2'd1, 4'b0000);
    step(1'b0, 1'b1, 8'h33, 2'd3, 4'b0000);
    step(1'b0, 1'b0, 8'h00, 2'd1, 4'b0010);
    step(1'b0, 1'b0, 8'h00, 2'd0, 4'b1111);
    // full throughput on f0
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, k[7:0], 2'd0, 4'b0001);
    end
    step(1'b0, 1'b0, 8'h00, 2'd0, 4'b0001);
    // reset with f_valid=1011 stalled, then normal traffic on f1
    step(1'b0, 1'b1, 8'hA0, 2'd0, 4'b0000);
    step(1'b0, 1'b1, 8'hA1, 2'd1, 4'b0000);
    step(1'b0, 1'b1, 8'hA3, 2'd3, 4'b0000);
    step(1'b1, 1'b1, 8'h55, 2'd1, 4'b0000);
    step(1'b0, 1'b1, 8'h77, 2'd1, 4'b0000);
    step(1'b0, 1'b0, 8'h00, 2'd0, 4'b1111);
`endif

    // random traffic, including occasional resets
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
           2'($urandom_range(0, 3)), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
